// File: rtl/pkg_period_meter.sv
// Shared types for the period meter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   state_t : measurement FSM states (IDLE, WAIT_FIRST, MEASURE)
package pkg_period_meter;

  // IDLE       : disabled, counter parked at 0
  // WAIT_FIRST : armed, waiting for the rising edge that opens a period
  // MEASURE    : counting cycles between consecutive rising edges
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

endpackage

// File: rtl/mod_sync_edge.sv
// Synchronises an asynchronous level into i_clk_in and emits rise/fall pulses.
// Latency: input change to pulse is SYNC_STAGES+1 cycles (sync chain, delay flop, pulse flop).
// Backpressure: none; pulses are one cycle wide and are not held.
//
// Ports:
//   i_clk_in : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset, clears the whole chain to 0
//   i_sig    : asynchronous input level
//   o_rise   : one-cycle pulse after a synchronised 0->1 transition
//   o_fall   : one-cycle pulse after a synchronised 1->0 transition
module mod_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk_in,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   dly_q;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // The pulses are registered so the FSM downstream only ever sees flop
  // outputs; this adds the cycle that makes edge-to-o_valid SYNC_STAGES+2.
  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig};
      dly_q  <= sync_lvl;
      o_rise <= sync_lvl & ~dly_q;
      o_fall <= ~sync_lvl & dly_q;
    end
  end

endmodule

// File: rtl/mod_period_meter.sv
// Measures period (rise to rise) and high time (rise to fall) of an async square wave.
// Latency: o_valid pulses SYNC_STAGES+2 cycles after the closing rising edge at i_sig.
// Backpressure: none; o_valid is a one-cycle strobe, o_period/o_high hold until the next one.
//
// Ports:
//   i_clk_in  : system clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_enable  : 1 = measure, 0 = return to IDLE and clear o_timeout
//   i_sig     : asynchronous square wave under measurement
//   o_period  : last period in i_clk_in cycles
//   o_high    : high time of that period in i_clk_in cycles (0 if no fall was seen)
//   o_valid   : one-cycle strobe when o_period/o_high update
//   o_timeout : sticky, set when the cycle counter saturates
module mod_period_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk_in,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_sig,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic [CNT_WIDTH-1:0] o_high,
  output logic                 o_valid,
  output logic                 o_timeout
);

  import pkg_period_meter::*;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] high_latch_q;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 cnt_sat;
  logic                 sig_rise;
  logic                 sig_fall;

  mod_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .i_clk_in (i_clk_in),
    .i_rst_n  (i_rst_n),
    .i_sig    (i_sig),
    .o_rise   (sig_rise),
    .o_fall   (sig_fall)
  );

  // cnt_q counts cycles elapsed since the opening rise minus one, so the
  // value reported on an edge is always cnt_q+1.
  assign cnt_inc = cnt_q + CNT_ONE;
  assign cnt_sat = (cnt_q == CNT_MAX);

  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      high_latch_q <= '0;
      o_period     <= '0;
      o_high       <= '0;
      o_valid      <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_valid <= 1'b0;

      if (!i_enable) begin
        // Abort whatever was in flight; outputs other than the flag hold.
        state_q      <= IDLE;
        cnt_q        <= '0;
        high_latch_q <= '0;
        o_timeout    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= WAIT_FIRST;
            cnt_q   <= '0;
          end

          WAIT_FIRST: begin
            cnt_q <= '0;
            if (sig_rise) begin
              state_q      <= MEASURE;
              high_latch_q <= '0;
            end
          end

          MEASURE: begin
            if (sig_rise) begin
              // A rise always restarts the period. If it lands on the
              // saturated count the true period is 2^CNT_WIDTH, which does
              // not fit, so it is flagged instead of reported.
              cnt_q        <= '0;
              high_latch_q <= '0;
              if (cnt_sat) begin
                o_timeout <= 1'b1;
              end else begin
                o_period <= cnt_inc;
                o_high   <= high_latch_q;
                o_valid  <= 1'b1;
              end
            end else if (cnt_sat) begin
              o_timeout    <= 1'b1;
              state_q      <= WAIT_FIRST;
              cnt_q        <= '0;
              high_latch_q <= '0;
            end else begin
              cnt_q <= cnt_inc;
              if (sig_fall) begin
                high_latch_q <= cnt_inc;
              end
            end
          end

          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_period_meter.sv
// Self-checking bench for mod_period_meter: a 16-bit and an 8-bit instance share
// clock, reset and enable; each has its own i_sig. Expected pulses are derived
// from the recorded input edge times.
module tb_mod_period_meter;

  localparam int          S      = 2;
  localparam int unsigned LAT    = S + 2;
  localparam int unsigned MAX16  = 65536;
  localparam int unsigned MAX8   = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sig16;
  logic        sig8;
  logic [15:0] period16;
  logic [15:0] high16;
  logic        valid16;
  logic        to16;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        to8;

  always #5 clk = ~clk;

  mod_period_meter #(.CNT_WIDTH(16), .SYNC_STAGES(S)) u_dut16 (
    .i_clk_in  (clk),
    .i_rst_n   (rst_n),
    .i_enable  (en),
    .i_sig     (sig16),
    .o_period  (period16),
    .o_high    (high16),
    .o_valid   (valid16),
    .o_timeout (to16)
  );

  mod_period_meter #(.CNT_WIDTH(8), .SYNC_STAGES(S)) u_dut8 (
    .i_clk_in  (clk),
    .i_rst_n   (rst_n),
    .i_enable  (en),
    .i_sig     (sig8),
    .o_period  (period8),
    .o_high    (high8),
    .o_valid   (valid8),
    .o_timeout (to8)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned per;
    int unsigned hi;
  } vrec_t;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vrec_t got16[$];
  vrec_t got8[$];

  always @(negedge clk) begin : mon16
    vrec_t r;
    if (valid16 === 1'b1) begin
      r.cyc = cyc; r.per = 32'(period16); r.hi = 32'(high16);
      got16.push_back(r);
    end
  end

  always @(negedge clk) begin : mon8
    vrec_t r;
    if (valid8 === 1'b1) begin
      r.cyc = cyc; r.per = 32'(period8); r.hi = 32'(high8);
      got8.push_back(r);
    end
  end

  int unsigned rises16[$];
  int unsigned falls16[$];
  int unsigned rises8[$];
  int unsigned falls8[$];
  int unsigned base16 = 0;
  int unsigned base8  = 0;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w8, input logic v);
    if (w8) begin
      if (v && !sig8) rises8.push_back(cyc);
      else if (!v && sig8) falls8.push_back(cyc);
      sig8 = v;
    end else begin
      if (v && !sig16) rises16.push_back(cyc);
      else if (!v && sig16) falls16.push_back(cyc);
      sig16 = v;
    end
  endtask

  // Each entry is one period: rise, high for hi cycles, low for the rest.
  task automatic play(input bit w8, input int unsigned per[$], input int unsigned hi[$]);
    for (int i = 0; i < per.size(); i++) begin
      drive(w8, 1'b1);
      tick(hi[i]);
      drive(w8, 1'b0);
      tick(per[i] - hi[i]);
    end
  endtask

  task automatic new_seg();
    rises16 = {}; falls16 = {}; rises8 = {}; falls8 = {};
    base16 = got16.size();
    base8  = got8.size();
  endtask

  // Reference: the first rise of a segment only arms. Every later rise closes
  // the period opened by the previous rise; gaps below 2^W are reported with
  // the high time from the fall in between (0 if none), gaps of 2^W or more
  // are a timeout and the rise simply opens a new period.
  task automatic check_seg(input bit w8, input string tag);
    int unsigned rs[$];
    int unsigned fs[$];
    vrec_t       got[$];
    vrec_t       exp_q[$];
    vrec_t       e;
    int unsigned maxgap;
    int unsigned base;
    int unsigned gap;
    int unsigned hi;
    logic        act_to;
    logic        exp_to;
    if (w8) begin
      rs = rises8; fs = falls8; got = got8; base = base8; maxgap = MAX8; act_to = to8;
    end else begin
      rs = rises16; fs = falls16; got = got16; base = base16; maxgap = MAX16; act_to = to16;
    end
    exp_to = 1'b0;
    for (int i = 1; i < rs.size(); i++) begin
      gap = rs[i] - rs[i-1];
      if (gap < maxgap) begin
        hi = 0;
        foreach (fs[j]) if (fs[j] > rs[i-1] && fs[j] < rs[i]) hi = fs[j] - rs[i-1];
        e.cyc = rs[i] + LAT; e.per = gap; e.hi = hi;
        exp_q.push_back(e);
      end else begin
        exp_to = 1'b1;
      end
    end
    if (rs.size() > 0 && cyc >= rs[$] + maxgap + LAT) exp_to = 1'b1;
    chk({tag, " valid count"}, 64'(got.size() - base), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && base + k < got.size(); k++) begin
      chk({tag, " valid cycle"}, 64'(got[base+k].cyc), 64'(exp_q[k].cyc));
      chk({tag, " period"},      64'(got[base+k].per), 64'(exp_q[k].per));
      chk({tag, " high"},        64'(got[base+k].hi),  64'(exp_q[k].hi));
    end
    chk({tag, " timeout"}, 64'(act_to), 64'(exp_to));
  endtask

  initial begin
    int unsigned p[$];
    int unsigned h[$];
    int unsigned t;
    int unsigned pp;

    rst_n = 1'b0; en = 1'b0; sig16 = 1'b0; sig8 = 1'b0;
    tick(3);
    chk("reset period16", 64'(period16), 0);
    chk("reset high16",   64'(high16),   0);
    chk("reset valid16",  64'(valid16),  0);
    chk("reset timeout16", 64'(to16),    0);
    chk("reset period8",  64'(period8),  0);
    chk("reset timeout8", 64'(to8),      0);
    rst_n = 1'b1;
    tick(2);
    en = 1'b1;
    tick(2);
    new_seg();

    // Three 2084-cycle periods, 50% duty: two measurements expected.
    p = {2084, 2084, 2084}; h = {1042, 1042, 1042};
    play(1'b0, p, h);
    chk("sq2084 period16", 64'(period16), 2084);
    chk("sq2084 high16",   64'(high16),   1042);

    // 8-bit instance: largest reportable gap, a gap exactly at 2^W, recovery.
    p = {100, 100, 255, 256, 50, 10}; h = {30, 30, 200, 10, 20, 5};
    play(1'b1, p, h);
    tick(8);
    check_seg(1'b1, "bound8");
    chk("bound8 period8", 64'(period8), 50);
    chk("bound8 high8",   64'(high8),   20);

    // Enable dropped for one cycle in the middle of a period.
    drive(1'b0, 1'b1); tick(200); drive(1'b0, 1'b0); tick(150);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    chk("abort timeout8 cleared", 64'(to8), 0);
    chk("abort timeout16",        64'(to16), 0);
    tick(1);
    new_seg();
    tick(100);
    drive(1'b0, 1'b1); tick(250); drive(1'b0, 1'b0); tick(350);
    drive(1'b0, 1'b1); tick(300); drive(1'b0, 1'b0); tick(8);
    chk("abort period16", 64'(period16), 600);
    chk("abort high16",   64'(high16),   250);

    // Saturation on the 8-bit instance after a single rise.
    t = cyc;
    drive(1'b1, 1'b1); tick(5); drive(1'b1, 1'b0);
    tick(t + 259 - cyc);
    chk("sat8 timeout before", 64'(to8), 0);
    tick(1);
    chk("sat8 timeout after", 64'(to8), 1);
    chk("sat8 period held",   64'(period8), 50);
    chk("sat8 high held",     64'(high8),   20);
    tick(20);
    p = {50, 30}; h = {20, 10};
    play(1'b1, p, h);
    tick(8);
    check_seg(1'b1, "sat8");

    // Asynchronous reset in the middle of a period.
    drive(1'b0, 1'b1); tick(120); drive(1'b0, 1'b0); tick(60);
    check_seg(1'b0, "pre_rst16");
    #2 rst_n = 1'b0;
    #1;
    chk("arst period16",  64'(period16), 0);
    chk("arst high16",    64'(high16),   0);
    chk("arst valid16",   64'(valid16),  0);
    chk("arst timeout16", 64'(to16),     0);
    chk("arst period8",   64'(period8),  0);
    chk("arst high8",     64'(high8),    0);
    chk("arst valid8",    64'(valid8),   0);
    chk("arst timeout8",  64'(to8),      0);
    @(posedge clk); #1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    new_seg();
    p = {300, 400, 500}; h = {100, 150, 200};
    play(1'b0, p, h);
    tick(8);
    check_seg(1'b0, "post_rst16");
    check_seg(1'b1, "post_rst8");

    // Random periods and duty cycles on both instances.
    p = {}; h = {};
    for (int i = 0; i < 20; i++) begin
      pp = $urandom_range(300, 2);
      p.push_back(pp);
      h.push_back($urandom_range(pp - 1, 1));
    end
    play(1'b1, p, h);
    p = {}; h = {};
    for (int i = 0; i < 15; i++) begin
      pp = $urandom_range(700, 2);
      p.push_back(pp);
      h.push_back($urandom_range(pp - 1, 1));
    end
    play(1'b0, p, h);
    tick(8);
    check_seg(1'b1, "rand8");
    check_seg(1'b0, "rand16");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
